// File: rtl/xor_serial_arbiter.sv
// Round-robin arbiter sharing a single 1-bit XOR between NREQ requesters.
// Each granted request is processed serially, LSB first, over WIDTH cycles.
module xor_serial_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      out,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     last_q, last_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  aShift_q, aShift_d;
  logic [WIDTH-1:0]  bShift_q, bShift_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              busy_q, busy_d;

  logic [PW-1:0]     winner;
  logic [PW-1:0]     cand;
  logic              anyReq;
  logic              sharedXor;

  // The one XOR gate every requester shares.
  assign sharedXor = aShift_q[0] ^ bShift_q[0];

  // Descending scan so the candidate closest after last_q is written last and wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    anyReq = |req;
    for (int k = NREQ; k >= 1; k--) begin
      cand = PW'((int'(last_q) + k) % NREQ);
      if (req[cand]) winner = cand;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    res_d    = res_q;
    out_d    = out_q;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          aShift_d      = a_in[int'(winner)*WIDTH +: WIDTH];
          bShift_d      = b_in[int'(winner)*WIDTH +: WIDTH];
          owner_d       = winner;
          last_d        = winner;
          gnt_d[winner] = 1'b1;
          cnt_d         = '0;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        res_d    = {sharedXor, res_q[WIDTH-1:1]};
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        out_d           = res_q;
        done_d[owner_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= PW'(NREQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      aShift_q <= '0;
      bShift_q <= '0;
      res_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      res_q    <= res_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Directed bench for xor_serial_arbiter (NREQ=2, WIDTH=16): timing of gnt/done/busy,
// XOR results, round-robin order, operand capture and asynchronous reset.
module tb_xor_serial_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [15:0] out;
  logic        busy;

  int assertCount;
  int failCount;
  int doneSeen;
  bit corruptAfterGnt;

  xor_serial_arbiter #(.NREQ(2), .WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .gnt   (gnt),
    .done  (done),
    .out   (out),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every done pulse so spurious completions (e.g. after an abort) show up.
  always @(negedge clk) if (done != 2'b00) doneSeen++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int who, input logic [15:0] a, input logic [15:0] b);
    a_in[who*16 +: 16] = a;
    b_in[who*16 +: 16] = b;
    req[who]           = 1'b1;
  endtask

  // Waits for the grant to 'who', then checks busy, done timing and the result.
  task automatic expectOp(input int who, input logic [15:0] expOut, input bit dropReq);
    int n;
    n = 0;
    while (gnt == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (gnt == 2'b00) begin
      checkOutput("gntTimeout", 32'd1, 32'd0);
      return;
    end
    checkOutput("gnt", gnt, 32'd1 << who);
    checkOutput("busyAtG", busy, 0);
    if (dropReq) req[who] = 1'b0;
    if (corruptAfterGnt) a_in[who*16 +: 16] = 16'h0000;
    @(negedge clk);
    checkOutput("busyG1", busy, 1);
    checkOutput("gntPulse", gnt, 0);
    repeat (15) @(negedge clk);
    checkOutput("doneEarly", done, 0);
    @(negedge clk);
    checkOutput("done", done, 32'd1 << who);
    checkOutput("out", out, expOut);
    checkOutput("busyG17", busy, 1);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    assertCount     = 0;
    failCount       = 0;
    doneSeen        = 0;
    corruptAfterGnt = 1'b0;
    a_in            = '0;
    b_in            = '0;
    resetDut();
    checkOutput("rstGnt", gnt, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstOut", out, 0);
    checkOutput("rstBusy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 16'hA5A5, 16'h0FF0);
    expectOp(0, 16'hAA55, 1'b1);

    applyStimulus(1, 16'hFFFF, 16'hFFFF);
    expectOp(1, 16'h0000, 1'b1);
    applyStimulus(0, 16'hFFFF, 16'h0000);
    expectOp(0, 16'hFFFF, 1'b1);
    applyStimulus(1, 16'h8001, 16'h0001);
    expectOp(1, 16'h8000, 1'b1);

    resetDut();
    applyStimulus(0, 16'h1234, 16'h00FF);
    applyStimulus(1, 16'hFFFF, 16'h0F0F);
    rst_n = 1'b1;
    expectOp(0, 16'h12CB, 1'b1);
    expectOp(1, 16'hF0F0, 1'b1);

    applyStimulus(0, 16'h1111, 16'h2222);
    applyStimulus(1, 16'hF00F, 16'h0FF0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) expectOp(0, 16'h3333, 1'b0);
      else            expectOp(1, 16'hFFFF, 1'b0);
    end
    req = 2'b00;
    repeat (20) @(negedge clk);

    corruptAfterGnt = 1'b1;
    applyStimulus(0, 16'h00F0, 16'h000F);
    expectOp(0, 16'h00FF, 1'b1);
    corruptAfterGnt = 1'b0;

    applyStimulus(0, 16'h1234, 16'h4321);
    n = 0;
    while (gnt == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abortGnt", gnt, 2'b01);
    req[0] = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncOut", out, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncDone", done, 0);
    checkOutput("asyncGnt", gnt, 0);
    repeat (2) @(negedge clk);
    applyStimulus(0, 16'h1234, 16'h00FF);
    applyStimulus(1, 16'hFFFF, 16'h0F0F);
    rst_n = 1'b1;
    expectOp(0, 16'h12CB, 1'b1);
    expectOp(1, 16'hF0F0, 1'b1);
    repeat (20) @(negedge clk);

    checkOutput("doneTotal", doneSeen, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
